// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf output arbiter: packet field layout,
// controller state encoding, credit sizing and a packet-assembly helper.
package leaf_pkg;

   localparam int PKT_W           = 49;
   localparam int PAYLOAD_W       = 32;
   localparam int PKT_VLD_BIT     = 48;
   localparam int LEAF_LSB        = 43;
   localparam int LEAF_W          = 5;
   localparam int DPORT_LSB       = 39;
   localparam int DPORT_W         = 4;
   localparam int SEQ_LSB         = 32;
   localparam int SEQ_W           = 7;
   localparam int CREDIT_W        = 8;
   localparam int CREDIT_INIT_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   function automatic logic [PKT_W-1:0] build_pkt(
      input logic [LEAF_W-1:0]    leaf,
      input logic [DPORT_W-1:0]   dport,
      input logic [SEQ_W-1:0]     seq,
      input logic [PAYLOAD_W-1:0] payload
   );
      logic [PKT_W-1:0] p;
      p                        = '0;
      p[PKT_VLD_BIT]           = 1'b1;
      p[LEAF_LSB +: LEAF_W]    = leaf;
      p[DPORT_LSB +: DPORT_W]  = dport;
      p[SEQ_LSB +: SEQ_W]      = seq;
      p[0 +: PAYLOAD_W]        = payload;
      return p;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-request round-robin arbiter.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   en_i        - grant permitted this cycle
//   req_i[3:0]  - eligible requesters
//   gnt_o[3:0]  - one-hot grant (combinational)
//   gnt_idx_o   - index of the granted requester
// The search starts one above the last granted index and wraps; the pointer
// resets to 3 so requester 0 has first priority out of reset.
module rr_arbiter4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [3:0] req_i,
   output logic [3:0] gnt_o,
   output logic [1:0] gnt_idx_o
);

   logic [1:0] ptr_q;
   logic [1:0] ptr_d;
   logic [1:0] cand;
   logic       found;

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      cand  = '0;
      found = 1'b0;
      // k = 4 wraps back to ptr_q itself, i.e. the last-granted port is lowest priority
      for (int k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && en_i && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            ptr_d        = cand;
         end
      end
   end

   assign gnt_idx_o = ptr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 2'd3;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: merges four user word streams into one BFT packet
// stream with per-port credits, sequence numbers and destination config.
// Ports:
//   clk, reset_n                    - clock, async active-low reset
//   ap_start, resend                - start pulse, link pause level
//   din_leaf_user2interface         - 4 user words, port 1 in the LSBs
//   vld_user2interface / ack_...    - per-port valid / one-hot accept strobe
//   cfg_we/cfg_port/cfg_leaf/cfg_dport - destination config write
//   cr_vld/cr_port/cr_amt           - credit return
//   dout_leaf_interface2bft/dout_vld/dout_rdy - packet output handshake
//
// state | meaning
// IDLE  | waiting for ap_start
// RUN   | arbitrating and issuing packets
// DRAIN | link paused, finishing the in-flight packet
// HOLD  | link paused, output empty, waiting for resend to drop
module leaf_out_arbiter
   import leaf_pkg::*;
#(
   parameter int PACKET_BITS   = PKT_W,
   parameter int PAYLOAD_BITS  = PAYLOAD_W,
   parameter int NUM_OUT_PORTS = 4,
   parameter int CREDIT_INIT   = CREDIT_INIT_DEF
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  ap_start,
   input  logic                                  resend,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
   input  logic                                  cfg_we,
   input  logic [1:0]                            cfg_port,
   input  logic [LEAF_W-1:0]                     cfg_leaf,
   input  logic [DPORT_W-1:0]                    cfg_dport,
   input  logic                                  cr_vld,
   input  logic [1:0]                            cr_port,
   input  logic [CREDIT_W-1:0]                   cr_amt,
   output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
   output logic                                  dout_vld,
   input  logic                                  dout_rdy
);

   state_t                   state_q;
   logic                     vld_q;
   logic [PACKET_BITS-1:0]   dout_q;
   logic [SEQ_W-1:0]         seq_q    [4];
   logic [SEQ_W-1:0]         seq_d    [4];
   logic [CREDIT_W-1:0]      credit_q [4];
   logic [CREDIT_W-1:0]      credit_d [4];
   logic [LEAF_W-1:0]        leaf_q   [4];
   logic [DPORT_W-1:0]       dport_q  [4];
   logic [PAYLOAD_BITS-1:0]  word     [4];
   logic [3:0]               elig;
   logic [3:0]               gnt;
   logic [1:0]               gidx;
   logic                     grant_en;
   logic [PACKET_BITS-1:0]   pkt_d;
   logic [CREDIT_W:0]        csum [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         word[i] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
         elig[i] = vld_user2interface[i] && (credit_q[i] != '0);
      end
   end

   // A grant needs the output register free now, either empty or leaving this cycle.
   assign grant_en = (state_q == ST_RUN) && (!vld_q || dout_rdy);

   rr_arbiter4 u_rr (
      .clk       (clk),
      .rst_n     (reset_n),
      .en_i      (grant_en),
      .req_i     (elig),
      .gnt_o     (gnt),
      .gnt_idx_o (gidx)
   );

   // ack is the grant itself so a dout_rdy release can be answered in the same cycle.
   assign ack_interface2user = gnt;

   // Packet uses the config registers as they stand before any same-cycle write.
   assign pkt_d = build_pkt(leaf_q[gidx], dport_q[gidx], seq_q[gidx], word[gidx]);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         // 9-bit sum: credit is at least 1 whenever it is granted, so no underflow.
         csum[i] = {1'b0, credit_q[i]} - (CREDIT_W+1)'(gnt[i])
                 + ((cr_vld && cr_port == 2'(i)) ? {1'b0, cr_amt} : '0);
         credit_d[i] = csum[i][CREDIT_W] ? {CREDIT_W{1'b1}} : csum[i][CREDIT_W-1:0];
         if (cfg_we && cfg_port == 2'(i)) begin
            seq_d[i] = '0;
         end else if (gnt[i]) begin
            seq_d[i] = seq_q[i] + 1'b1;
         end else begin
            seq_d[i] = seq_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         vld_q   <= 1'b0;
         dout_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            seq_q[i]    <= '0;
            credit_q[i] <= CREDIT_W'(CREDIT_INIT);
            leaf_q[i]   <= '0;
            dport_q[i]  <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE:  if (ap_start) state_q <= ST_RUN;
            ST_RUN:   if (resend)   state_q <= ST_DRAIN;
            ST_DRAIN: if (!vld_q)   state_q <= ST_HOLD;
            ST_HOLD:  if (!resend)  state_q <= ST_RUN;
            default:                state_q <= ST_IDLE;
         endcase

         if (|gnt) begin
            vld_q  <= 1'b1;
            dout_q <= pkt_d;
         end else if (vld_q && dout_rdy) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
         end

         for (int i = 0; i < 4; i++) begin
            seq_q[i]    <= seq_d[i];
            credit_q[i] <= credit_d[i];
            if (cfg_we && cfg_port == 2'(i)) begin
               leaf_q[i]  <= cfg_leaf;
               dport_q[i] <= cfg_dport;
            end
         end
      end
   end

   assign dout_leaf_interface2bft = dout_q;
   assign dout_vld                = vld_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
module tb_leaf_out_arbiter;

   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HOLD = 3;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         ap_start, resend;
   logic [127:0] din;
   logic [3:0]   vld, ack;
   logic         cfg_we;
   logic [1:0]   cfg_port;
   logic [4:0]   cfg_leaf;
   logic [3:0]   cfg_dport;
   logic         cr_vld;
   logic [1:0]   cr_port;
   logic [7:0]   cr_amt;
   logic [48:0]  dout;
   logic         dout_vld, dout_rdy;

   int errors = 0;
   int checks = 0;

   int m_state, m_ptr, m_vld;
   int m_cred [4];
   int m_seq  [4];
   int m_leaf [4];
   int m_dport[4];
   logic [48:0] sb[$];

   logic [3:0]  last_ack;
   logic        last_vld;
   logic [48:0] last_dout;

   always #5 clk = ~clk;

   leaf_out_arbiter dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .ap_start                (ap_start),
      .resend                  (resend),
      .din_leaf_user2interface (din),
      .vld_user2interface      (vld),
      .ack_interface2user      (ack),
      .cfg_we                  (cfg_we),
      .cfg_port                (cfg_port),
      .cfg_leaf                (cfg_leaf),
      .cfg_dport               (cfg_dport),
      .cr_vld                  (cr_vld),
      .cr_port                 (cr_port),
      .cr_amt                  (cr_amt),
      .dout_leaf_interface2bft (dout),
      .dout_vld                (dout_vld),
      .dout_rdy                (dout_rdy)
   );

   task automatic clear_inputs();
      ap_start = 0; resend = 0; din = '0; vld = '0;
      cfg_we = 0; cfg_port = '0; cfg_leaf = '0; cfg_dport = '0;
      cr_vld = 0; cr_port = '0; cr_amt = '0; dout_rdy = 1;
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_ptr = 3; m_vld = 0;
      for (int i = 0; i < 4; i++) begin
         m_cred[i] = 64; m_seq[i] = 0; m_leaf[i] = 0; m_dport[i] = 0;
      end
      sb.delete();
   endtask

   // One clock: called just after a falling edge with inputs set; samples, steps model, returns after next falling edge.
   task automatic tick();
      logic [3:0]  exp_ack;
      logic [48:0] pkt;
      int g, idx, nv, c;
      #2;
      exp_ack = '0; g = -1;
      if (m_state == M_RUN && (m_vld == 0 || dout_rdy)) begin
         for (int k = 1; k <= 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (g < 0 && vld[idx] && m_cred[idx] > 0) g = idx;
         end
      end
      if (g >= 0) exp_ack[g] = 1'b1;
      last_ack = ack; last_vld = dout_vld; last_dout = dout;
      checks++;
      if (ack !== exp_ack) begin
         errors++; $display("FAIL ack @%0t: got %b expected %b", $time, ack, exp_ack);
      end
      checks++;
      if (dout_vld !== (m_vld != 0)) begin
         errors++; $display("FAIL dout_vld @%0t: got %b expected %0d", $time, dout_vld, m_vld);
      end
      checks++;
      if (m_vld != 0) begin
         if (sb.size() == 0 || dout !== sb[0]) begin
            errors++; $display("FAIL packet @%0t: got %h expected %h", $time, dout, (sb.size() == 0) ? 49'h0 : sb[0]);
         end
      end else if (dout !== 49'h0) begin
         errors++; $display("FAIL idle_zero @%0t: got %h expected 0", $time, dout);
      end
      nv = m_vld;
      if (m_vld != 0 && dout_rdy) begin
         if (sb.size() > 0) void'(sb.pop_front());
         nv = 0;
      end
      if (g >= 0) begin
         pkt = {1'b1, 5'(m_leaf[g]), 4'(m_dport[g]), 7'(m_seq[g]), din[g*32 +: 32]};
         sb.push_back(pkt);
         nv = 1;
         m_seq[g] = (m_seq[g] + 1) % 128;
         m_cred[g] = m_cred[g] - 1;
         m_ptr = g;
      end
      if (cr_vld) begin
         c = m_cred[cr_port] + cr_amt;
         m_cred[cr_port] = (c > 255) ? 255 : c;
      end
      if (cfg_we) begin
         m_leaf[cfg_port] = cfg_leaf; m_dport[cfg_port] = cfg_dport; m_seq[cfg_port] = 0;
      end
      case (m_state)
         M_IDLE:  if (ap_start) m_state = M_RUN;
         M_RUN:   if (resend) m_state = M_DRAIN;
         M_DRAIN: if (m_vld == 0) m_state = M_HOLD;
         M_HOLD:  if (!resend) m_state = M_RUN;
         default: m_state = M_IDLE;
      endcase
      m_vld = nv;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 0;
      clear_inputs();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset_n = 0;
      clear_inputs();
      model_reset();
      #2;
      checks++;
      if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
      checks++;
      if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", dout_vld); end
      checks++;
      if (dout !== 49'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
      @(negedge clk);
      reset_n = 1;
      tick();
      vld = 4'hF; din = {4{32'h1234_5678}};
      tick();   // still IDLE: no grant expected
      vld = 4'h0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] order [8];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000;
      order[4] = 4'b0001; order[5] = 4'b0010; order[6] = 4'b0100; order[7] = 4'b1000;
      ap_start = 1; tick(); ap_start = 0;
      vld = 4'hF; dout_rdy = 1;
      for (int n = 0; n < 12; n++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         ap_start = (n == 5);
         tick();
         if (n < 8) begin
            checks++;
            if (last_ack !== order[n]) begin
               errors++; $display("FAIL rr_order[%0d]: got %b expected %b", n, last_ack, order[n]);
            end
         end
      end
      ap_start = 0; vld = '0;
      tick();
   endtask

   task automatic test_format();
      logic [48:0] exp_pkt;
      exp_pkt = {1'b1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF};
      cfg_we = 1; cfg_port = 2'd0; cfg_leaf = 5'd5; cfg_dport = 4'd2;
      tick();
      cfg_we = 0;
      vld = 4'b0001; din = {96'h0, 32'hDEADBEEF};
      tick();
      vld = 4'b0000;
      checks++;
      if (dout !== exp_pkt || dout_vld !== 1'b1) begin
         errors++; $display("FAIL format: got %h/%b expected %h/1", dout, dout_vld, exp_pkt);
      end
      // write in the same cycle as a grant: this grant keeps the old destination
      vld = 4'b0001; din = {96'h0, 32'hCAFE_0001};
      cfg_we = 1; cfg_port = 2'd0; cfg_leaf = 5'd9; cfg_dport = 4'd7;
      tick();
      cfg_we = 0; din = {96'h0, 32'hCAFE_0002};
      tick();
      vld = '0;
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      vld = 4'hF; dout_rdy = 1;
      for (int n = 0; n < 3; n++) begin din = {$urandom, $urandom, $urandom, $urandom}; tick(); end
      dout_rdy = 0;
      for (int n = 0; n < 5; n++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         tick();
         checks++;
         if (last_ack !== 4'b0 || last_vld !== 1'b1) begin
            errors++; $display("FAIL hold_noack[%0d]: got ack %b vld %b expected ack 0000 vld 1", n, last_ack, last_vld);
         end
      end
      dout_rdy = 1;
      tick();
      checks++;
      if (last_ack === 4'b0) begin
         errors++; $display("FAIL release_ack: got %b expected a grant", last_ack);
      end
      vld = '0;
      tick(); tick();
   endtask

   task automatic test_credit();
      int cnt1, cnt_other;
      do_reset();
      ap_start = 1; tick(); ap_start = 0;
      vld = 4'b0010; dout_rdy = 1;
      for (int n = 0; n < 64; n++) begin din = {$urandom, $urandom, $urandom, $urandom}; tick(); end
      vld = 4'hF; cnt1 = 0; cnt_other = 0;
      for (int n = 0; n < 12; n++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (last_ack[1]) cnt1++;
         if (last_ack[0] || last_ack[2] || last_ack[3]) cnt_other++;
      end
      checks++;
      if (cnt1 != 0) begin errors++; $display("FAIL credit_block: got %0d grants on port 2 expected 0", cnt1); end
      checks++;
      if (cnt_other != 12) begin errors++; $display("FAIL others_served: got %0d expected 12", cnt_other); end
      cr_vld = 1; cr_port = 2'd1; cr_amt = 8'd1;
      tick();
      cr_vld = 0; cnt1 = 0;
      for (int n = 0; n < 12; n++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (last_ack[1]) cnt1++;
      end
      checks++;
      if (cnt1 != 1) begin errors++; $display("FAIL credit_resume: got %0d grants on port 2 expected 1", cnt1); end
      vld = '0;
      tick();
   endtask

   task automatic test_resend();
      int cnt;
      vld = 4'hF; dout_rdy = 1; din = {$urandom, $urandom, $urandom, $urandom};
      tick();
      dout_rdy = 0; resend = 1;
      for (int n = 0; n < 3; n++) tick();
      dout_rdy = 1;
      tick();
      checks++;
      if (last_ack !== 4'b0) begin errors++; $display("FAIL drain_noack: got %b expected 0000", last_ack); end
      checks++;
      if (dout_vld !== 1'b0 || dout !== 49'h0) begin
         errors++; $display("FAIL drain_done: got vld %b dout %h expected 0/0", dout_vld, dout);
      end
      cnt = 0;
      for (int n = 0; n < 4; n++) begin tick(); if (last_ack !== 4'b0) cnt++; end
      checks++;
      if (cnt != 0) begin errors++; $display("FAIL hold_noack: got %0d grants expected 0", cnt); end
      resend = 0; cnt = 0;
      for (int n = 0; n < 4; n++) begin tick(); if (last_ack !== 4'b0) cnt++; end
      checks++;
      if (cnt != 3) begin errors++; $display("FAIL resume_run: got %0d grants expected 3", cnt); end
      vld = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      vld = 4'hF; dout_rdy = 1; din = {$urandom, $urandom, $urandom, $urandom};
      tick();
      dout_rdy = 0; vld = '0;
      tick();
      #3;
      reset_n = 0;
      #1;
      checks++;
      if (dout_vld !== 1'b0 || dout !== 49'h0 || ack !== 4'b0) begin
         errors++; $display("FAIL mid_reset: got vld %b dout %h ack %b expected 0/0/0", dout_vld, dout, ack);
      end
      clear_inputs();
      model_reset();
      @(negedge clk);
      reset_n = 1;
      tick(); tick();
   endtask

   task automatic test_seq_wrap_sat();
      int cnt;
      logic [6:0] seen [300];
      int nseen;
      do_reset();
      cr_vld = 1; cr_port = 2'd2; cr_amt = 8'd186;
      tick();
      cr_amt = 8'd10;
      tick();
      cr_vld = 0;
      ap_start = 1; tick(); ap_start = 0;
      vld = 4'b0100; dout_rdy = 1;
      cnt = 0; nseen = 0;
      for (int n = 0; n < 271; n++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         if (n == 0) begin cr_vld = 1; cr_port = 2'd2; cr_amt = 8'd5; end
         else cr_vld = 0;
         tick();
         if (last_ack[2]) cnt++;
         if (last_vld && nseen < 300) begin seen[nseen] = last_dout[38:32]; nseen++; end
      end
      checks++;
      if (cnt != 256) begin errors++; $display("FAIL sat_grants: got %0d expected 256", cnt); end
      checks++;
      if (nseen < 130) begin
         errors++; $display("FAIL seq_count: got %0d packets expected at least 130", nseen);
      end else if (seen[127] !== 7'd127 || seen[128] !== 7'd0 || seen[129] !== 7'd1) begin
         errors++; $display("FAIL seq_wrap: got %0d,%0d,%0d expected 127,0,1", seen[127], seen[128], seen[129]);
      end
      vld = '0;
      tick();
   endtask

   initial begin
      clear_inputs();
      reset_n = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_format();
      test_backpressure();
      test_resend();
      test_reset_mid();
      test_credit();
      test_seq_wrap_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
